// File: rtl/fifo_ast_pkg.sv
// Shared types for the bt656 FIFO read-side drain.
// Word layout is {eop, sop, pixel}, eop in the MSB.
package fifo_ast_pkg;

    localparam int PIX_W   = 16;
    localparam int SOP_BIT = PIX_W;
    localparam int EOP_BIT = PIX_W + 1;

    typedef struct packed {
        logic             eop;
        logic             sop;
        logic [PIX_W-1:0] pixel;
    } fifo_word_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } rd_state_t;

    // Bit position of a flag for an arbitrary pixel width.
    function automatic int flag_idx(input int bit_pos, input int data_w);
        return bit_pos - PIX_W + data_w;
    endfunction

endpackage

// File: rtl/ast_skid_buf.sv
// Circular output buffer for the Avalon-ST source.
// Head entry is presented directly; depth need not be a power of two.
import fifo_ast_pkg::*;

module ast_skid_buf #(
    parameter int W     = 18,
    parameter int DEPTH = 4,
    parameter int OCC_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [OCC_W-1:0] occ,
    output logic [W-1:0]     head,
    output logic             not_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign not_empty = (occ != '0);
    assign pop_ok    = pop && not_empty;
    assign head      = not_empty ? mem[rd_ptr] : '0;

    // Storage array; contents only matter between push and pop.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keeps occ.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop_ok})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_ast_reader.sv
// Drains the dual-clock pixel FIFO, checks packet framing and
// drives an Avalon-ST source with full ready/valid backpressure.
import fifo_ast_pkg::*;

module fifo_ast_reader #(
    parameter int DATA_W     = 16,
    parameter int OBUF_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W+1:0] fifo_q,
    input  logic              fifo_rdempty,
    output logic              fifo_rdreq,
    input  logic              enable,
    input  logic              aso_ready,
    output logic              aso_valid,
    output logic [DATA_W-1:0] aso_data,
    output logic              aso_startofpacket,
    output logic              aso_endofpacket,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int W       = DATA_W + 2;
    localparam int OCC_W   = $clog2(OBUF_DEPTH + 1);
    localparam int SOP_IDX = flag_idx(SOP_BIT, DATA_W);
    localparam int EOP_IDX = flag_idx(EOP_BIT, DATA_W);

    rd_state_t        state;
    rd_state_t        state_nxt;
    logic             inflight;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   pend;
    logic             obuf_valid;
    logic [W-1:0]     head;
    logic             push;
    logic             pop;
    logic             drop_inc;
    logic             err_inc;
    logic             q_sop;
    logic             q_eop;

    assign q_sop = fifo_q[SOP_IDX];
    assign q_eop = fifo_q[EOP_IDX];
    assign pend  = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
    assign pop   = obuf_valid && aso_ready;

    // Pop request: reserve buffer room for words already in flight.
    // When disabled, read one word at a time so we stop on eop.
    always_comb begin
        fifo_rdreq = 1'b0;
        if (!reset && !fifo_rdempty) begin
            if (enable) begin
                fifo_rdreq = (pend < (OCC_W+1)'(OBUF_DEPTH));
            end else begin
                fifo_rdreq = (state == IN_PKT) && !inflight &&
                             (occ < OCC_W'(OBUF_DEPTH));
            end
        end
    end

    // Tracks that a q word is due on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rdreq;
        end
    end

    // Framing state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Framing decisions for each captured word.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        drop_inc  = 1'b0;
        err_inc   = 1'b0;
        if (inflight) begin
            case (state)
                IDLE: begin
                    if (!q_sop) begin
                        drop_inc = 1'b1;
                    end else begin
                        push      = 1'b1;
                        state_nxt = q_eop ? IDLE : IN_PKT;
                    end
                end
                IN_PKT: begin
                    push      = 1'b1;
                    err_inc   = q_sop;
                    state_nxt = q_eop ? IDLE : IN_PKT;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Saturating drop and framing-error counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (drop_inc && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
            if (err_inc && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

    ast_skid_buf #(
        .W     (W),
        .DEPTH (OBUF_DEPTH),
        .OCC_W (OCC_W)
    ) u_obuf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (fifo_q),
        .pop       (pop),
        .occ       (occ),
        .head      (head),
        .not_empty (obuf_valid)
    );

    assign aso_valid         = obuf_valid;
    assign aso_data          = head[DATA_W-1:0];
    assign aso_startofpacket = head[SOP_IDX];
    assign aso_endofpacket   = head[EOP_IDX];

endmodule

// File: tb/tb_fifo_ast_reader.sv
// Directed bench for fifo_ast_reader with a behavioural
// non-show-ahead FIFO model and an Avalon-ST beat collector.
module tb_fifo_ast_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [17:0] fifo_q = '0;
    logic        fifo_rdempty = 1'b1;
    logic        fifo_rdreq;
    logic        enable = 1'b1;
    logic        aso_ready = 1'b1;
    logic        aso_valid;
    logic [15:0] aso_data;
    logic        aso_startofpacket;
    logic        aso_endofpacket;
    logic [15:0] drop_cnt;
    logic [15:0] err_cnt;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    logic [17:0] fifo_mem [0:255];
    int          wr_idx = 0;
    int          rd_idx = 0;
    logic        eop_seen = 1'b0;

    logic [17:0] beats [$];
    int          beat_cyc [$];
    int          rd_cyc [$];
    int          late_rd = 0;
    int          stall_bad = 0;
    logic        prev_stall = 1'b0;
    logic [18:0] prev_out = '0;

    fifo_ast_reader #(
        .DATA_W     (16),
        .OBUF_DEPTH (4),
        .CNT_W      (16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .fifo_q            (fifo_q),
        .fifo_rdempty      (fifo_rdempty),
        .fifo_rdreq        (fifo_rdreq),
        .enable            (enable),
        .aso_ready         (aso_ready),
        .aso_valid         (aso_valid),
        .aso_data          (aso_data),
        .aso_startofpacket (aso_startofpacket),
        .aso_endofpacket   (aso_endofpacket),
        .drop_cnt          (drop_cnt),
        .err_cnt           (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: q appears one cycle after rdreq, not cleared by reset.
    always @(posedge clk) begin
        if (fifo_rdreq) begin
            fifo_q <= fifo_mem[rd_idx[7:0]];
            rd_idx <= rd_idx + 1;
            if (!enable && fifo_mem[rd_idx[7:0]][17]) eop_seen <= 1'b1;
        end
        fifo_rdempty <= ((fifo_rdreq ? rd_idx + 1 : rd_idx) == wr_idx);
    end

    // Beat collector and stall-stability watcher.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall &&
                ({aso_valid, aso_endofpacket, aso_startofpacket, aso_data} != prev_out))
                stall_bad++;
            if (fifo_rdreq) rd_cyc.push_back(cyc);
            if (fifo_rdreq && eop_seen && !enable) late_rd++;
            if (aso_valid && aso_ready) begin
                beats.push_back({aso_endofpacket, aso_startofpacket, aso_data});
                beat_cyc.push_back(cyc);
            end
            prev_stall = aso_valid && !aso_ready;
            prev_out = {aso_valid, aso_endofpacket, aso_startofpacket, aso_data};
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] mk(input logic eop, input logic sop,
                                       input logic [15:0] px);
        return {eop, sop, px};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fpush(input logic [17:0] w);
        fifo_mem[wr_idx[7:0]] = w;
        wr_idx = wr_idx + 1;
    endtask

    task automatic wait_beats(input int target, input int budget);
        int k = 0;
        while (beats.size() < target && k < budget) begin
            tick();
            k++;
        end
        if (beats.size() < target) check("timeout", beats.size(), target);
    endtask

    initial begin
        int b0;
        int r0;
        int k;
        bit [3:0] pat;

        repeat (3) tick();
        check("rst_rdreq", fifo_rdreq, 0);
        reset = 1'b0;
        tick();
        check("rst_valid", aso_valid, 0);
        check("rst_data", {aso_endofpacket, aso_startofpacket, aso_data}, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_err", err_cnt, 0);

        // 1: back-to-back packet
        b0 = beats.size();
        r0 = rd_cyc.size();
        fpush(mk(0, 1, 16'h0010));
        fpush(mk(0, 0, 16'h0011));
        fpush(mk(0, 0, 16'h0012));
        fpush(mk(1, 0, 16'h0013));
        wait_beats(b0 + 4, 40);
        repeat (5) tick();
        for (int i = 0; i < 4; i++)
            check("t1_beat", beats[b0 + i], mk(i == 3, i == 0, 16'h0010 + 16'(i)));
        check("t1_rdreq_n", rd_cyc.size() - r0, 4);
        check("t1_rdreq_span", rd_cyc[r0 + 3] - rd_cyc[r0], 3);
        check("t1_beat_span", beat_cyc[b0 + 3] - beat_cyc[b0], 3);

        // 2: same packet under ready pattern 1,0,0,1
        b0 = beats.size();
        pat = 4'b1001;
        fpush(mk(0, 1, 16'h0010));
        fpush(mk(0, 0, 16'h0011));
        fpush(mk(0, 0, 16'h0012));
        fpush(mk(1, 0, 16'h0013));
        for (int i = 0; i < 40; i++) begin
            aso_ready = pat[i % 4];
            tick();
        end
        aso_ready = 1'b1;
        repeat (5) tick();
        check("t2_count", beats.size() - b0, 4);
        for (int i = 0; i < 4; i++)
            check("t2_beat", beats[b0 + i], mk(i == 3, i == 0, 16'h0010 + 16'(i)));
        check("t2_stall_hold", stall_bad, 0);

        // 3: sop-less words are dropped
        b0 = beats.size();
        repeat (3) fpush(mk(0, 0, 16'h00AA));
        fpush(mk(1, 1, 16'h0001));
        wait_beats(b0 + 1, 40);
        repeat (5) tick();
        check("t3_drop", drop_cnt, 3);
        check("t3_count", beats.size() - b0, 1);
        check("t3_beat", beats[b0], mk(1, 1, 16'h0001));

        // 4: sop inside a packet
        b0 = beats.size();
        fpush(mk(0, 1, 16'h0001));
        fpush(mk(0, 0, 16'h0002));
        fpush(mk(1, 1, 16'h0003));
        wait_beats(b0 + 3, 40);
        repeat (5) tick();
        check("t4_err", err_cnt, 1);
        check("t4_count", beats.size() - b0, 3);
        check("t4_b0", beats[b0], mk(0, 1, 16'h0001));
        check("t4_b1", beats[b0 + 1], mk(0, 0, 16'h0002));
        check("t4_b2", beats[b0 + 2], mk(1, 1, 16'h0003));

        // 5: enable falls mid-packet
        b0 = beats.size();
        aso_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            fpush(mk(i == 7, i == 0, 16'h0100 + 16'(i)));
        fpush(mk(0, 1, 16'h0200));
        fpush(mk(1, 0, 16'h0201));
        repeat (15) tick();
        r0 = rd_cyc.size();
        enable = 1'b0;
        aso_ready = 1'b1;
        wait_beats(b0 + 8, 60);
        repeat (20) tick();
        check("t5_count", beats.size() - b0, 8);
        for (int i = 0; i < 8; i++)
            check("t5_beat", beats[b0 + i], mk(i == 7, i == 0, 16'h0100 + 16'(i)));
        check("t5_rd_after", rd_cyc.size() - r0, 4);
        check("t5_late_rd", late_rd, 0);
        check("t5_left", wr_idx - rd_idx, 2);
        enable = 1'b1;
        wait_beats(b0 + 10, 40);
        repeat (3) tick();
        check("t5_next0", beats[b0 + 8], mk(0, 1, 16'h0200));
        check("t5_next1", beats[b0 + 9], mk(1, 0, 16'h0201));

        // 6: reset while a word is in flight
        aso_ready = 1'b0;
        fpush(mk(0, 1, 16'h0300));
        fpush(mk(0, 0, 16'h0301));
        repeat (8) tick();
        check("t6_valid_pre", aso_valid, 1);
        fpush(mk(0, 0, 16'h0302));
        k = 0;
        while (!fifo_rdreq && k < 20) begin
            tick();
            k++;
        end
        check("t6_rdreq", fifo_rdreq, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        aso_ready = 1'b1;
        b0 = beats.size();
        check("t6_valid", aso_valid, 0);
        check("t6_drop", drop_cnt, 0);
        check("t6_err", err_cnt, 0);
        repeat (10) tick();
        check("t6_no_beat", beats.size() - b0, 0);

        // recovery after reset
        fpush(mk(1, 1, 16'h0055));
        wait_beats(b0 + 1, 40);
        repeat (3) tick();
        check("t6_recover", beats[b0], mk(1, 1, 16'h0055));
        check("t6_drop_post", drop_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
